// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer.
// master = requester/consumer side, slave = the sequencer.
interface shift_sequencer_if #(
    parameter int AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [1:0]       in_mode;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;

    modport master (
        output in_valid, in_data, in_mode, in_amt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_amt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle controller that iterates an external one-bit shifter/rotator.
// Optional macro SHSEQ_AMT_REDUCE_EN shortens latency by reducing the amount at acceptance.
module shift_sequencer #(
    parameter int AMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_sequencer_if.slave   bus,
    output logic [3:0]         sh_x,
    output logic [1:0]         sh_m,
    input  logic [3:0]         sh_z
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_acc;
    logic [1:0]       r_mode;
    logic [AMT_W-1:0] r_cnt;
    logic [3:0]       w_load_acc;
    logic [AMT_W-1:0] w_load_cnt;
    logic             w_accept;

    assign w_accept = (r_state == IDLE) && bus.in_valid;

`ifdef SHSEQ_AMT_REDUCE_EN
    // Rotations repeat every 4 steps; shifts by 4 or more always empty the operand.
    always_comb begin
        w_load_acc = bus.in_data;
        w_load_cnt = bus.in_amt;
        if (bus.in_mode[1]) begin
            w_load_cnt = bus.in_amt & AMT_W'(3);
        end else if (int'(bus.in_amt) >= 4) begin
            w_load_acc = '0;
            w_load_cnt = '0;
        end
    end
`else
    assign w_load_acc = bus.in_data;
    assign w_load_cnt = bus.in_amt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.in_valid) w_next = (w_load_cnt == '0) ? DONE : RUN;
            RUN:  if (r_cnt == AMT_W'(1)) w_next = DONE;
            DONE: if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_mode <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_acc  <= w_load_acc;
            r_mode <= bus.in_mode;
            r_cnt  <= w_load_cnt;
        end else if (r_state == RUN) begin
            r_acc  <= sh_z;
            r_cnt  <= r_cnt - AMT_W'(1);
        end
    end

    assign bus.out_data = r_acc;
    assign sh_x         = r_acc;
    assign sh_m         = r_mode;
endmodule
